// File: rtl/m602_pulse_amp.sv
// Dual-channel one-shot pulse amplifier: a qualified falling edge on a trigger input produces
// a fixed-width registered pulse, followed by an optional lockout window.
module m602_pulse_amp #(
  parameter int unsigned PULSE_COUNT_H2 = 10,
  parameter int unsigned PULSE_COUNT_N2 = 10,
  parameter int unsigned RECOVERY_COUNT = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic D2,
  input  logic E2,
  output logic H2,
  output logic J2,
  input  logic K2,
  input  logic L2,
  output logic N2,
  output logic P2
);

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StRecover
  } state_e;

  logic [1:0] trig_in;
  logic [1:0] cond_in;
  logic [1:0] pulse_out;

  assign trig_in = {K2, D2};
  assign cond_in = {L2, E2};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    localparam int unsigned PulseCount = (g == 0) ? PULSE_COUNT_H2 : PULSE_COUNT_N2;
    localparam logic [15:0] PulseLoad  = 16'(PulseCount - 1);
    // Only used when RECOVERY_COUNT > 0, so the wrap at zero is never loaded.
    localparam logic [15:0] RecLoad    = 16'(RECOVERY_COUNT - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        prev_q;
    logic        pulse_q;
    logic        fire;

    assign fire = prev_q & ~trig_in[g] & cond_in[g];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        prev_q <= trig_in[g];
        unique case (state_q)
          StIdle: begin
            if (fire) begin
              state_q <= StPulse;
              cnt_q   <= PulseLoad;
              pulse_q <= 1'b1;
            end
          end
          StPulse: begin
            if (cnt_q == '0) begin
              pulse_q <= 1'b0;
              if (RECOVERY_COUNT > 0) begin
                state_q <= StRecover;
                cnt_q   <= RecLoad;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          StRecover: begin
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
          end
        endcase
      end
    end

    assign pulse_out[g] = pulse_q;
  end

  assign H2 = pulse_out[0];
  assign J2 = ~pulse_out[0];
  assign N2 = pulse_out[1];
  assign P2 = ~pulse_out[1];

endmodule

// File: tb/tb_m602_pulse_amp.sv
// Directed bench for m602_pulse_amp: one instance with long pulses and recovery, one with
// minimum-width pulses and no recovery.
module tb_m602_pulse_amp;

  logic clk;
  logic reset_n;
  logic d2a, e2a, k2a, l2a, h2a, j2a, n2a, p2a;
  logic d2b, e2b, k2b, l2b, h2b, j2b, n2b, p2b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic d, e, k, l;
    logic h, n;
  } vec_t;

  vec_t vecs[$];

  m602_pulse_amp #(
    .PULSE_COUNT_H2(10),
    .PULSE_COUNT_N2(3),
    .RECOVERY_COUNT(5)
  ) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .D2     (d2a),
    .E2     (e2a),
    .H2     (h2a),
    .J2     (j2a),
    .K2     (k2a),
    .L2     (l2a),
    .N2     (n2a),
    .P2     (p2a)
  );

  m602_pulse_amp #(
    .PULSE_COUNT_H2(1),
    .PULSE_COUNT_N2(2),
    .RECOVERY_COUNT(0)
  ) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .D2     (d2b),
    .E2     (e2b),
    .H2     (h2b),
    .J2     (j2b),
    .K2     (k2b),
    .L2     (l2b),
    .N2     (n2b),
    .P2     (p2b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input int rep, input logic d, input logic e, input logic k,
                              input logic l, input logic h, input logic n);
    vec_t v;
    v.d = d; v.e = e; v.k = k; v.l = l; v.h = h; v.n = n;
    for (int r = 0; r < rep; r++) vecs.push_back(v);
  endfunction

  initial begin
    // After-reset hold with both triggers low: a reset-value prev of 1 would fire here.
    add(3, 0, 1, 0, 1, 0, 0);
    // Simultaneous triggers on both channels: 10-cycle H2, 3-cycle N2.
    add(1, 1, 1, 1, 1, 0, 0);
    add(3, 0, 1, 0, 1, 1, 1);
    add(7, 0, 1, 0, 1, 1, 0);
    add(5, 0, 1, 0, 1, 0, 0);
    add(2, 0, 1, 0, 1, 0, 0);
    // Falling edges with conditioning low, then conditioning raised with trigger still low.
    add(1, 1, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 1, 0, 0);
    // Edges at cycles 0, 4, 12, 16, then one on the RECOVER->IDLE edge (cycle 31).
    add(1, 1, 1, 0, 1, 0, 0);
    add(3, 0, 1, 0, 1, 1, 0);
    add(1, 1, 1, 0, 1, 1, 0);
    add(6, 0, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, 1, 0, 0);
    add(3, 0, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, 1, 0, 0);
    add(10, 0, 1, 0, 1, 1, 0);
    add(4, 0, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, 1, 0, 0);
    add(4, 0, 1, 0, 1, 0, 0);
    // Conditioning dropped mid-pulse on channel B: full 3-cycle pulse anyway.
    add(1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 1);
    add(2, 0, 1, 0, 0, 0, 1);
    add(6, 0, 1, 0, 1, 0, 0);

    d2a = 0; e2a = 1; k2a = 0; l2a = 1;
    d2b = 0; e2b = 1; k2b = 0; l2b = 1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    // Checked before the first clock edge: reset must act without clk.
    #1;
    check("reset H2a", h2a, 1'b0);
    check("reset J2a", j2a, 1'b1);
    check("reset N2a", n2a, 1'b0);
    check("reset P2a", p2a, 1'b1);
    check("reset H2b", h2b, 1'b0);
    check("reset N2b", n2b, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      d2a = vecs[i].d; e2a = vecs[i].e; k2a = vecs[i].k; l2a = vecs[i].l;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d H2", i), h2a, vecs[i].h);
      check($sformatf("vec%0d J2", i), j2a, ~vecs[i].h);
      check($sformatf("vec%0d N2", i), n2a, vecs[i].n);
      check($sformatf("vec%0d P2", i), p2a, ~vecs[i].n);
    end

    // No recovery: D2 toggles each cycle, pulses 1 wide on every falling edge; K2 with a
    // 2-cycle pulse sees every other falling edge land on its PULSE->IDLE edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d2b = (i % 2 == 0);
      k2b = (i % 2 == 0);
      @(posedge clk);
      #1;
      check($sformatf("tog%0d H2", i), h2b, logic'(i % 2 == 1));
      check($sformatf("tog%0d J2", i), j2b, logic'(i % 2 == 0));
      check($sformatf("tog%0d N2", i), n2b, logic'(i % 4 == 1 || i % 4 == 2));
      check($sformatf("tog%0d P2", i), p2b, logic'(!(i % 4 == 1 || i % 4 == 2)));
    end
    @(negedge clk);
    d2b = 0; k2b = 0;

    // Reset asserted at pulse cycle 5 kills the pulse immediately and for good.
    @(negedge clk);
    d2a = 1;
    @(posedge clk);
    #1 check("rst pre H2", h2a, 1'b0);
    @(negedge clk);
    d2a = 0;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk);
      #1 check($sformatf("rst pulse%0d H2", c), h2a, 1'b1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("rst mid H2", h2a, 1'b0);
    check("rst mid J2", j2a, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst after%0d H2", c), h2a, 1'b0);
      check($sformatf("rst after%0d J2", c), j2a, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
